// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier front panel.
//   mult_state_t : controller states (LOAD, RUN, FIX, DONE)
//   BYTE_W       : width of one switch-loaded byte and one product read-back byte
//   abs_mag()    : magnitude of a width-bit value, or the raw value when unsigned
package mult_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {LOAD, RUN, FIX, DONE} mult_state_t;

    // value holds a width-bit operand zero-extended to 64 bits. The result is
    // reduced modulo 2^width, so the most negative operand yields 2^(width-1),
    // which still fits as an unsigned width-bit magnitude.
    function automatic logic [63:0] abs_mag(input logic [63:0] value,
                                            input logic        signed_en,
                                            input int          width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        if (signed_en && value[width-1])
            abs_mag = (~value + 64'd1) & mask;
        else
            abs_mag = value & mask;
    endfunction

endpackage

// File: rtl/byte_loader.sv
// Debounced byte loader for the multiplier front panel.
//   clk, rst_n : clock, asynchronous active-low reset
//   set        : load request level; one byte is taken per lock cycle
//   unlock     : re-arms set once set has been released
//   enable     : loading is allowed in the current controller state
//   accept     : a byte is taken on this clock
//   last       : byte_idx points at the final load byte
//   byte_idx   : index of the next byte to load
//   byte_we    : one-hot write enable for the byte being taken
module byte_loader #(
    parameter int NBYTES = 4,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set,
    input  logic              unlock,
    input  logic              enable,
    output logic              accept,
    output logic              last,
    output logic [SEL_W-1:0]  byte_idx,
    output logic [NBYTES-1:0] byte_we
);

    logic lock;

    assign accept = set & ~lock & enable;
    assign last   = (byte_idx == SEL_W'(NBYTES - 1));

    always_comb begin
        byte_we = '0;
        if (accept)
            byte_we[byte_idx] = 1'b1;
    end

    // A held set takes the lock, so only one byte goes in until unlock is
    // seen with set released; set and unlock together leave a taken lock alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock     <= 1'b0;
            byte_idx <= '0;
        end else begin
            if (accept) begin
                lock     <= 1'b1;
                byte_idx <= last ? '0 : byte_idx + 1'b1;
            end else if (unlock && !set) begin
                lock <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_mult_controller.sv
// Byte-loaded sequential shift-add multiplier with signed/unsigned mode.
//   clk, rst_n : clock, asynchronous active-low reset
//   inp        : switch byte to load
//   set/unlock : debounced load request pair
//   sgn        : 1 = two's complement multiply, sampled with the last load byte
//   select     : product byte driven on out
//   out        : product[8*select +: 8]
//   busy       : multiply in progress (RUN or FIX)
//   done       : product ready (DONE)
//   byte_idx   : index of the next byte to load
//   setled     : mirror of set
//   unlockled  : mirror of unlock
module seq_mult_controller
    import mult_pkg::*;
#(
    parameter  int WIDTH  = 16,
    localparam int NBYTES = 2 * WIDTH / BYTE_W,
    localparam int SEL_W  = $clog2(NBYTES),
    localparam int CNT_W  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       inp,
    input  logic             set,
    input  logic             unlock,
    input  logic             sgn,
    input  logic [SEL_W-1:0] select,
    output logic [7:0]       out,
    output logic             busy,
    output logic             done,
    output logic [SEL_W-1:0] byte_idx,
    output logic             setled,
    output logic             unlockled
);

    mult_state_t        state;
    logic [2*WIDTH-1:0] ab;
    logic [2*WIDTH-1:0] ab_nxt;
    logic [WIDTH-1:0]   a_nxt;
    logic [WIDTH-1:0]   b_nxt;
    logic [WIDTH-1:0]   ma;
    logic [WIDTH-1:0]   mb;
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] pp;
    logic [CNT_W-1:0]   iter;
    logic               neg;
    logic               load_en;
    logic               accept;
    logic               last;
    logic [NBYTES-1:0]  byte_we;

    assign setled    = set;
    assign unlockled = unlock;
    assign load_en   = (state == LOAD) || (state == DONE);

    byte_loader #(
        .NBYTES (NBYTES),
        .SEL_W  (SEL_W)
    ) u_loader (
        .clk      (clk),
        .rst_n    (rst_n),
        .set      (set),
        .unlock   (unlock),
        .enable   (load_en),
        .accept   (accept),
        .last     (last),
        .byte_idx (byte_idx),
        .byte_we  (byte_we)
    );

    // A and B are kept as one vector {B, A} so load byte k is simply ab[8k +: 8].
    // The merged next value lets the final byte feed the magnitude capture directly.
    always_comb begin
        ab_nxt = ab;
        for (int k = 0; k < NBYTES; k++) begin
            if (byte_we[k])
                ab_nxt[BYTE_W*k +: BYTE_W] = inp;
        end
        a_nxt = ab_nxt[WIDTH-1:0];
        b_nxt = ab_nxt[2*WIDTH-1:WIDTH];
    end

    assign pp  = {{WIDTH{1'b0}}, ma} << iter;
    assign out = p[{select, 3'b000} +: BYTE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            ab    <= '0;
            ma    <= '0;
            mb    <= '0;
            p     <= '0;
            iter  <= '0;
            neg   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            ab <= ab_nxt;
            case (state)
                LOAD: begin
                    if (accept && last) begin
                        ma    <= WIDTH'(abs_mag(64'(a_nxt), sgn, WIDTH));
                        mb    <= WIDTH'(abs_mag(64'(b_nxt), sgn, WIDTH));
                        neg   <= sgn & (a_nxt[WIDTH-1] ^ b_nxt[WIDTH-1]);
                        p     <= '0;
                        iter  <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (mb[iter[CNT_W-2:0]])
                        p <= p + pp;
                    iter <= iter + 1'b1;
                    if (iter == CNT_W'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    // Magnitudes were multiplied; restore the sign of the result.
                    if (neg)
                        p <= -p;
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    if (accept) begin
                        state <= LOAD;
                        done  <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
